// File: rtl/seq_div_if.sv
// Handshake and result bundle for the iterative divider.
// The requester drives start/operands; the divider returns results and status.
interface seq_div_if #(
   parameter int DATA_WIDTH = 16
);
   logic                      start;
   logic [2*DATA_WIDTH-1:0]   dividend;
   logic [DATA_WIDTH-1:0]     divisor;
   logic [DATA_WIDTH-1:0]     quotient;
   logic [DATA_WIDTH-1:0]     remainder;
   logic                      busy;
   logic                      done;
   logic                      div_by_zero;
   logic                      overflow;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero, overflow
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero, overflow
   );
endinterface

// File: rtl/seq_div.sv
// Restoring shift-subtract divider, 2W/W -> W quotient and remainder.
// Produces one quotient bit per clock. Error cases finish after a single RUN cycle.
module seq_div #(
   parameter int DATA_WIDTH = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   seq_div_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   r_q, q_q, d_q;
   logic [CW-1:0]  cnt;
   logic           err_dbz, err_ovf;
   logic [W-1:0]   quo_q, rem_q;
   logic           dbz_q, ovf_q;

   logic           last, err, ge;
   logic [W:0]     t;
   logic [W-1:0]   r_nxt, q_nxt;

   // R < D holds before every step, so a set MSB of T alone means T >= D
   // and the W-bit difference never loses information.
   assign t     = {r_q, q_q[W-1]};
   assign ge    = t[W] | (t[W-1:0] >= d_q);
   assign r_nxt = ge ? (t[W-1:0] - d_q) : t[W-1:0];
   assign q_nxt = {q_q[W-2:0], ge};
   assign last  = (cnt == CW'(W - 1));
   assign err   = err_dbz | err_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (err || last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt     <= '0;
         err_dbz <= 1'b0;
         err_ovf <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               r_q     <= bus.dividend[2*W-1:W];
               q_q     <= bus.dividend[W-1:0];
               d_q     <= bus.divisor;
               cnt     <= '0;
               err_dbz <= (bus.divisor == '0);
               err_ovf <= (bus.divisor != '0) && (bus.dividend[2*W-1:W] >= bus.divisor);
            end
            RUN: if (err) begin
               // Visible results only move on the edge entering DONE.
               quo_q <= '1;
               rem_q <= '0;
               dbz_q <= err_dbz;
               ovf_q <= err_ovf;
            end else begin
               r_q <= r_nxt;
               q_q <= q_nxt;
               cnt <= cnt + CW'(1);
               if (last) begin
                  quo_q <= q_nxt;
                  rem_q <= r_nxt;
                  dbz_q <= 1'b0;
                  ovf_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.overflow    = ovf_q;
   assign bus.busy        = (state != IDLE);
   assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed vector table, hand-built corner sequences,
// and randomized operations checked against plain-arithmetic division.
module tb_seq_div;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seq_div_if #(.DATA_WIDTH(W)) bus ();
   seq_div #(.DATA_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   typedef struct {
      logic [31:0] dd;
      logic [15:0] dv;
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Called just after a negedge with the DUT idle; returns once busy drops.
   task automatic run_op(input logic [31:0] dd, input logic [15:0] dv, input bit poke,
                         output int lat, output int bcnt, output int dcnt,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dbz, output logic ovf, output bit stable);
      logic [15:0] q0, r0;
      q0 = bus.quotient;
      r0 = bus.remainder;
      lat = 0; bcnt = 0; dcnt = 0; stable = 1'b1;
      q = '0; r = '0; dbz = 1'b0; ovf = 1'b0;
      bus.dividend = dd;
      bus.divisor  = dv;
      bus.start    = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) bus.start = 1'b0;
         if (poke && i == 4) begin
            bus.start    = 1'b1;
            bus.dividend = 32'h1234_5678;
            bus.divisor  = 16'h0000;
         end
         if (poke && i == 5) bus.start = 1'b0;
         if (!bus.busy) break;
         bcnt++;
         if (bus.done) begin
            dcnt++;
            lat = i + 1;
            q   = bus.quotient;
            r   = bus.remainder;
            dbz = bus.div_by_zero;
            ovf = bus.overflow;
         end else if (bus.quotient !== q0 || bus.remainder !== r0) begin
            stable = 1'b0;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic check_op(input string nm, input logic [31:0] dd, input logic [15:0] dv,
                           input bit poke, input logic [15:0] eq, input logic [15:0] er,
                           input logic edbz, input logic eovf, input int elat);
      int lat, bcnt, dcnt;
      logic [15:0] q, r;
      logic dbz, ovf;
      bit stable;
      run_op(dd, dv, poke, lat, bcnt, dcnt, q, r, dbz, ovf, stable);
      chk({nm, " quotient"},  64'(q),    64'(eq));
      chk({nm, " remainder"}, 64'(r),    64'(er));
      chk({nm, " flags"},     64'({dbz, ovf}), 64'({edbz, eovf}));
      chk({nm, " latency"},   64'(lat),  64'(elat));
      chk({nm, " busy_cycles"}, 64'(bcnt), 64'(elat));
      chk({nm, " done_pulses"}, 64'(dcnt), 64'd1);
      chk({nm, " stable"},    64'(stable), 64'd1);
   endtask

   // Reference: ordinary integer division with the error rules on top.
   task automatic model(input logic [31:0] dd, input logic [15:0] dv,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic dbz, output logic ovf, output int lat);
      logic [31:0] dv32;
      dv32 = {16'h0, dv};
      dbz = 1'b0; ovf = 1'b0;
      if (dv == 16'h0) begin
         dbz = 1'b1; q = 16'hFFFF; r = 16'h0; lat = 2;
      end else if ((dd >> 16) >= dv32) begin
         ovf = 1'b1; q = 16'hFFFF; r = 16'h0; lat = 2;
      end else begin
         q = 16'(dd / dv32); r = 16'(dd % dv32); lat = W + 1;
      end
   endtask

   initial begin
      int n;
      logic [31:0] dd;
      logic [15:0] dv, eq, er;
      logic edbz, eovf;
      int elat;

      vecs[0] = '{32'd100000,     16'd300,    16'd333,    16'd100,    1'b0, 1'b0, 17};
      vecs[1] = '{32'hFFFE_0001,  16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b0, 17};
      vecs[2] = '{32'hFFFE_FFFF,  16'hFFFF,   16'hFFFF,   16'hFFFE,   1'b0, 1'b0, 17};
      vecs[3] = '{32'h1234_5678,  16'h0000,   16'hFFFF,   16'h0000,   1'b1, 1'b0, 2};
      vecs[4] = '{32'h0001_0000,  16'h0001,   16'hFFFF,   16'h0000,   1'b0, 1'b1, 2};
      vecs[5] = '{32'd1000,       16'd7,      16'd142,    16'd6,      1'b0, 1'b0, 17};
      vecs[6] = '{32'd0,          16'd5,      16'd0,      16'd0,      1'b0, 1'b0, 17};
      vecs[7] = '{32'h0000_FFFF,  16'h0001,   16'hFFFF,   16'h0000,   1'b0, 1'b0, 17};
      vecs[8] = '{32'd0,          16'd0,      16'hFFFF,   16'h0000,   1'b1, 1'b0, 2};
      vecs[9] = '{32'h0005_0000,  16'd5,      16'hFFFF,   16'h0000,   1'b0, 1'b1, 2};

      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;

      repeat (2) @(negedge clk);
      chk("reset busy_done", 64'({bus.busy, bus.done}), 64'd0);
      chk("reset results", 64'({bus.quotient, bus.remainder}), 64'd0);
      chk("reset flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      check_op("basic", 32'd100000, 16'd300, 1'b0, 16'd333, 16'd100, 1'b0, 1'b0, 17);

      // Asynchronous reset five cycles into a run.
      bus.dividend = 32'd100000;
      bus.divisor  = 16'd300;
      bus.start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_reset busy_done", 64'({bus.busy, bus.done}), 64'd0);
      chk("midrun_reset results", 64'({bus.quotient, bus.remainder}), 64'd0);
      chk("midrun_reset flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) n++;
      end
      chk("post_reset no_activity", 64'(n), 64'd0);

      for (int i = 0; i < 10; i++)
         check_op($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, 1'b0,
                  vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf, vecs[i].lat);

      // Start pulsed mid-run is ignored; next op goes in the idle cycle after done.
      check_op("busy_poke", 32'd100000, 16'd300, 1'b1, 16'd333, 16'd100, 1'b0, 1'b0, 17);
      check_op("back_to_back", 32'd1000, 16'd7, 1'b0, 16'd142, 16'd6, 1'b0, 1'b0, 17);

      // Held start: a new error op is accepted at every return to idle.
      bus.dividend = 32'd7;
      bus.divisor  = 16'd0;
      bus.start    = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done) n++;
      end
      bus.start = 1'b0;
      chk("held_start done_count", 64'(n), 64'd4);
      n = 0;
      while (bus.busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("held_start drains", 64'(bus.busy), 64'd0);

      for (int k = 0; k < 40; k++) begin
         dv = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
         if (dv != 16'h0 && $urandom_range(0, 4) != 0)
            dd = {16'($urandom_range(0, int'(dv) - 1)), 16'($urandom)};
         else
            dd = $urandom;
         model(dd, dv, eq, er, edbz, eovf, elat);
         check_op($sformatf("rand%0d", k), dd, dv, 1'b0, eq, er, edbz, eovf, elat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
